// File: rtl/sys_cmd_ctrl_if.sv
// rtl/sys_cmd_ctrl_if.sv - bus bundle between the command controller and UART RX, RF, ALU and TX FIFO
interface sys_cmd_ctrl_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ALU_OUT_W = 16,
    parameter int FUN_W     = 4
);
    logic [DATA_W-1:0]    RX_P_Data;
    logic                 RX_D_VLD;
    logic [ALU_OUT_W-1:0] ALU_OUT;
    logic                 ALU_OUT_Valid;
    logic [DATA_W-1:0]    RegFile_RdData;
    logic                 RegFile_RdData_Valid;
    logic                 FIFO_FULL;

    logic                 ClkGating_EN;
    logic                 ClkDiv_EN;
    logic                 ALU_EN;
    logic [FUN_W-1:0]     ALU_FUN;
    logic [ADDR_W-1:0]    RegFile_Address;
    logic                 RegFile_WrEn;
    logic                 RegFile_RdEn;
    logic [DATA_W-1:0]    RegFile_WrData;
    logic [DATA_W-1:0]    FIFO_WrData;
    logic                 FIFO_WrInc;
    logic                 Frame_Err;
    logic                 Busy;

    modport master (
        input  RX_P_Data, RX_D_VLD, ALU_OUT, ALU_OUT_Valid,
               RegFile_RdData, RegFile_RdData_Valid, FIFO_FULL,
        output ClkGating_EN, ClkDiv_EN, ALU_EN, ALU_FUN, RegFile_Address,
               RegFile_WrEn, RegFile_RdEn, RegFile_WrData, FIFO_WrData,
               FIFO_WrInc, Frame_Err, Busy
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, ALU_OUT, ALU_OUT_Valid,
               RegFile_RdData, RegFile_RdData_Valid, FIFO_FULL,
        input  ClkGating_EN, ClkDiv_EN, ALU_EN, ALU_FUN, RegFile_Address,
               RegFile_WrEn, RegFile_RdEn, RegFile_WrData, FIFO_WrData,
               FIFO_WrInc, Frame_Err, Busy
    );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - byte-framed command parser driving RF, ALU and TX FIFO
module sys_cmd_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ALU_OUT_W = 16,
    parameter int FUN_W     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          CLK,
    input  logic          RST,
    sys_cmd_ctrl_if.master bus
);
    localparam int NBYTES   = ALU_OUT_W / DATA_W;
    localparam int IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [DATA_W-1:0] OP_WR    = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] OP_RD    = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] OP_BURST = DATA_W'(8'hEE);
    localparam logic [DATA_W-1:0] OP_ALU   = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] OP_ALUNO = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CNT, GET_OPA, GET_OPB, GET_FUN,
        RD_REQ, RD_WAIT, ALU_WAIT, TX_PUSH
    } state_t;

    typedef enum logic [1:0] {M_WR, M_RD, M_BURST, M_ALU} mode_t;

    state_t               state, state_nxt;
    mode_t                mode, mode_nxt;
    logic [ADDR_W-1:0]    addr_r, addr_nxt;
    logic [DATA_W-1:0]    cnt_r, cnt_nxt;
    logic [ALU_OUT_W-1:0] result_r, result_nxt;
    logic [IW-1:0]        idx_r, idx_nxt, last_r, last_nxt;
    logic [TW-1:0]        tmo_cnt, tmo_nxt;
    logic [DATA_W-1:0]    cur_byte;
    logic                 in_get;

    logic                 wren_nxt, rden_nxt, alu_en_nxt, wrinc_nxt, ferr_nxt;
    logic                 cg_nxt, busy_nxt;
    logic [ADDR_W-1:0]    address_nxt;
    logic [DATA_W-1:0]    wrdata_nxt, fifo_data_nxt;
    logic [FUN_W-1:0]     fun_nxt;

    // Result bytes leave LSB first; idx_r selects the byte currently offered to the FIFO.
    assign cur_byte = DATA_W'(result_r >> (idx_r * DATA_W));
    assign in_get   = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CNT) ||
                      (state == GET_OPA)  || (state == GET_OPB)  || (state == GET_FUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        addr_nxt      = addr_r;
        cnt_nxt       = cnt_r;
        result_nxt    = result_r;
        idx_nxt       = idx_r;
        last_nxt      = last_r;
        tmo_nxt       = '0;
        wren_nxt      = 1'b0;
        rden_nxt      = 1'b0;
        alu_en_nxt    = 1'b0;
        wrinc_nxt     = 1'b0;
        ferr_nxt      = 1'b0;
        address_nxt   = bus.RegFile_Address;
        wrdata_nxt    = bus.RegFile_WrData;
        fun_nxt       = bus.ALU_FUN;
        fifo_data_nxt = bus.FIFO_WrData;

        case (state)
            IDLE: if (bus.RX_D_VLD) begin
                case (bus.RX_P_Data)
                    OP_WR:    begin mode_nxt = M_WR;    state_nxt = GET_ADDR; end
                    OP_RD:    begin mode_nxt = M_RD;    state_nxt = GET_ADDR; end
                    OP_BURST: begin mode_nxt = M_BURST; state_nxt = GET_ADDR; end
                    OP_ALU:   begin mode_nxt = M_ALU;   state_nxt = GET_OPA;  end
                    OP_ALUNO: begin mode_nxt = M_ALU;   state_nxt = GET_FUN;  end
                    default:  ferr_nxt = 1'b1;
                endcase
            end
            GET_ADDR: if (bus.RX_D_VLD) begin
                addr_nxt = bus.RX_P_Data[ADDR_W-1:0];
                case (mode)
                    M_WR:    state_nxt = GET_DATA;
                    M_BURST: state_nxt = GET_CNT;
                    default: begin
                        state_nxt   = RD_REQ;
                        rden_nxt    = 1'b1;
                        address_nxt = bus.RX_P_Data[ADDR_W-1:0];
                    end
                endcase
            end
            GET_DATA: if (bus.RX_D_VLD) begin
                wren_nxt    = 1'b1;
                address_nxt = addr_r;
                wrdata_nxt  = bus.RX_P_Data;
                state_nxt   = IDLE;
            end
            GET_CNT: if (bus.RX_D_VLD) begin
                if (bus.RX_P_Data == '0) begin
                    ferr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt     = bus.RX_P_Data;
                    rden_nxt    = 1'b1;
                    address_nxt = addr_r;
                    state_nxt   = RD_REQ;
                end
            end
            GET_OPA: if (bus.RX_D_VLD) begin
                wren_nxt    = 1'b1;
                address_nxt = '0;
                wrdata_nxt  = bus.RX_P_Data;
                state_nxt   = GET_OPB;
            end
            GET_OPB: if (bus.RX_D_VLD) begin
                wren_nxt    = 1'b1;
                address_nxt = ADDR_W'(1);
                wrdata_nxt  = bus.RX_P_Data;
                state_nxt   = GET_FUN;
            end
            GET_FUN: if (bus.RX_D_VLD) begin
                alu_en_nxt = 1'b1;
                fun_nxt    = bus.RX_P_Data[FUN_W-1:0];
                state_nxt  = ALU_WAIT;
            end
            RD_REQ: state_nxt = RD_WAIT;
            RD_WAIT: if (bus.RegFile_RdData_Valid) begin
                result_nxt = ALU_OUT_W'(bus.RegFile_RdData);
                idx_nxt    = '0;
                last_nxt   = '0;
                state_nxt  = TX_PUSH;
            end
            ALU_WAIT: if (bus.ALU_OUT_Valid) begin
                result_nxt = bus.ALU_OUT;
                idx_nxt    = '0;
                last_nxt   = IW'(NBYTES - 1);
                state_nxt  = TX_PUSH;
            end
            TX_PUSH: begin
                // The byte is presented even while the FIFO is full so WrData is stable at push time.
                fifo_data_nxt = cur_byte;
                if (!bus.FIFO_FULL) begin
                    wrinc_nxt = 1'b1;
                    if (idx_r == last_r) begin
                        idx_nxt = '0;
                        if (mode == M_BURST) cnt_nxt = cnt_r - 1'b1;
                        if (mode == M_BURST && cnt_r > DATA_W'(1)) begin
                            addr_nxt    = addr_r + 1'b1;
                            address_nxt = addr_r + 1'b1;
                            rden_nxt    = 1'b1;
                            state_nxt   = RD_REQ;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx_r + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Operand consumption is gated by RX_D_VLD, so abandoning a frame here has no side effect.
        if (TIMEOUT != 0 && in_get && !bus.RX_D_VLD) begin
            if (tmo_cnt == TW'(TMO_LAST)) begin
                ferr_nxt  = 1'b1;
                state_nxt = IDLE;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end

        cg_nxt   = (state_nxt == GET_FUN) || (state_nxt == ALU_WAIT);
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode                <= M_WR;
            addr_r              <= '0;
            cnt_r               <= '0;
            result_r            <= '0;
            idx_r               <= '0;
            last_r              <= '0;
            tmo_cnt             <= '0;
            bus.ClkGating_EN    <= 1'b0;
            bus.ClkDiv_EN       <= 1'b1;
            bus.ALU_EN          <= 1'b0;
            bus.ALU_FUN         <= '0;
            bus.RegFile_Address <= '0;
            bus.RegFile_WrEn    <= 1'b0;
            bus.RegFile_RdEn    <= 1'b0;
            bus.RegFile_WrData  <= '0;
            bus.FIFO_WrData     <= '0;
            bus.FIFO_WrInc      <= 1'b0;
            bus.Frame_Err       <= 1'b0;
            bus.Busy            <= 1'b0;
        end else begin
            mode                <= mode_nxt;
            addr_r              <= addr_nxt;
            cnt_r               <= cnt_nxt;
            result_r            <= result_nxt;
            idx_r               <= idx_nxt;
            last_r              <= last_nxt;
            tmo_cnt             <= tmo_nxt;
            bus.ClkGating_EN    <= cg_nxt;
            bus.ClkDiv_EN       <= 1'b1;
            bus.ALU_EN          <= alu_en_nxt;
            bus.ALU_FUN         <= fun_nxt;
            bus.RegFile_Address <= address_nxt;
            bus.RegFile_WrEn    <= wren_nxt;
            bus.RegFile_RdEn    <= rden_nxt;
            bus.RegFile_WrData  <= wrdata_nxt;
            bus.FIFO_WrData     <= fifo_data_nxt;
            bus.FIFO_WrInc      <= wrinc_nxt;
            bus.Frame_Err       <= ferr_nxt;
            bus.Busy            <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb/tb_sys_cmd_ctrl.sv - directed self-checking bench for sys_cmd_ctrl
module tb_sys_cmd_ctrl;
    logic CLK;
    logic RST;

    sys_cmd_ctrl_if bus ();

    sys_cmd_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  rf [16];
    int          n_wr = 0, n_rd = 0, n_alu = 0, n_ferr = 0, n_cg = 0;
    logic [3:0]  last_wr_addr;
    logic [7:0]  last_wr_data;
    logic [3:0]  last_fun;
    logic [7:0]  pushed [$];
    logic [3:0]  rd_addrs [$];
    logic        rd_pend = 1'b0, alu_pend = 1'b0;
    logic [3:0]  rd_pend_addr = '0;
    logic [15:0] alu_res = '0;

    // RF and ALU answer one cycle after their enable; observed strobes are logged here.
    always @(negedge CLK) begin
        if (bus.RegFile_WrEn) begin
            rf[bus.RegFile_Address] = bus.RegFile_WrData;
            last_wr_addr = bus.RegFile_Address;
            last_wr_data = bus.RegFile_WrData;
            n_wr++;
        end
        if (bus.RegFile_RdEn) begin
            n_rd++;
            rd_addrs.push_back(bus.RegFile_Address);
        end
        if (bus.ALU_EN) begin
            n_alu++;
            last_fun = bus.ALU_FUN;
        end
        if (bus.FIFO_WrInc) pushed.push_back(bus.FIFO_WrData);
        if (bus.Frame_Err) n_ferr++;
        if (bus.ClkGating_EN) n_cg++;

        bus.RegFile_RdData_Valid = rd_pend;
        bus.RegFile_RdData       = rd_pend ? rf[rd_pend_addr] : 8'h00;
        rd_pend      = bus.RegFile_RdEn;
        rd_pend_addr = bus.RegFile_Address;

        bus.ALU_OUT_Valid = alu_pend;
        bus.ALU_OUT       = alu_pend ? alu_res : 16'h0000;
        alu_pend = bus.ALU_EN;
        case (bus.ALU_FUN)
            4'd0:    alu_res = {8'h00, rf[0]} + {8'h00, rf[1]};
            4'd1:    alu_res = {8'h00, rf[0]} - {8'h00, rf[1]};
            default: alu_res = {8'h00, rf[0]} * {8'h00, rf[1]};
        endcase
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_pushes(input int target);
        for (int k = 0; k < 80 && pushed.size() < target; k++) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_chk++; if (bus.ClkDiv_EN !== 1'b1) begin n_err++; $display("FAIL reset_clkdiv: got %0b exp 1", bus.ClkDiv_EN); end
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b exp 0", bus.Busy); end
        n_chk++; if (bus.FIFO_WrInc !== 1'b0) begin n_err++; $display("FAIL reset_wrinc: got %0b exp 0", bus.FIFO_WrInc); end
        n_chk++; if (bus.RegFile_WrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %0b exp 0", bus.RegFile_WrEn); end
        n_chk++; if (bus.ClkGating_EN !== 1'b0) begin n_err++; $display("FAIL reset_cg: got %0b exp 0", bus.ClkGating_EN); end
        n_chk++; if (bus.Frame_Err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %0b exp 0", bus.Frame_Err); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int b_wr = n_wr;
        int b_push = pushed.size();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        repeat (4) tick();
        n_chk++; if (n_wr - b_wr != 1) begin n_err++; $display("FAIL wr_count: got %0d exp 1", n_wr - b_wr); end
        n_chk++; if (last_wr_addr !== 4'h5) begin n_err++; $display("FAIL wr_addr: got %h exp 5", last_wr_addr); end
        n_chk++; if (last_wr_data !== 8'h3C) begin n_err++; $display("FAIL wr_data: got %h exp 3c", last_wr_data); end
        n_chk++; if (pushed.size() != b_push) begin n_err++; $display("FAIL wr_no_push: got %0d exp %0d", pushed.size(), b_push); end
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL wr_idle: got %0b exp 0", bus.Busy); end
    endtask

    task automatic test_read();
        int b_rd = n_rd;
        int b_push = pushed.size();
        int b_q = rd_addrs.size();
        send_byte(8'hBB); send_byte(8'h05);
        wait_pushes(b_push + 1);
        repeat (3) tick();
        n_chk++; if (n_rd - b_rd != 1) begin n_err++; $display("FAIL rd_count: got %0d exp 1", n_rd - b_rd); end
        n_chk++; if (rd_addrs[b_q] !== 4'h5) begin n_err++; $display("FAIL rd_addr: got %h exp 5", rd_addrs[b_q]); end
        n_chk++; if (pushed.size() != b_push + 1) begin n_err++; $display("FAIL rd_push_cnt: got %0d exp %0d", pushed.size(), b_push + 1); end
        n_chk++; if (pushed[b_push] !== 8'h3C) begin n_err++; $display("FAIL rd_push_data: got %h exp 3c", pushed[b_push]); end
    endtask

    task automatic test_alu_ops();
        int b_alu = n_alu;
        int b_push = pushed.size();
        int b_cg = n_cg;
        send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
        wait_pushes(b_push + 2);
        repeat (3) tick();
        n_chk++; if (rf[0] !== 8'h10) begin n_err++; $display("FAIL alu_rf0: got %h exp 10", rf[0]); end
        n_chk++; if (rf[1] !== 8'h20) begin n_err++; $display("FAIL alu_rf1: got %h exp 20", rf[1]); end
        n_chk++; if (n_alu - b_alu != 1) begin n_err++; $display("FAIL alu_en_count: got %0d exp 1", n_alu - b_alu); end
        n_chk++; if (last_fun !== 4'h0) begin n_err++; $display("FAIL alu_fun: got %h exp 0", last_fun); end
        n_chk++; if (pushed.size() != b_push + 2) begin n_err++; $display("FAIL alu_push_cnt: got %0d exp %0d", pushed.size(), b_push + 2); end
        n_chk++; if (pushed[b_push] !== 8'h30) begin n_err++; $display("FAIL alu_byte0: got %h exp 30", pushed[b_push]); end
        n_chk++; if (pushed[b_push + 1] !== 8'h00) begin n_err++; $display("FAIL alu_byte1: got %h exp 00", pushed[b_push + 1]); end
        n_chk++; if (n_cg == b_cg) begin n_err++; $display("FAIL alu_cg_seen: got %0d cycles exp >0", n_cg - b_cg); end
        n_chk++; if (bus.ClkGating_EN !== 1'b0) begin n_err++; $display("FAIL alu_cg_off: got %0b exp 0", bus.ClkGating_EN); end
    endtask

    task automatic test_alu_no_ops();
        int b_push = pushed.size();
        send_byte(8'hDD); send_byte(8'h02);
        wait_pushes(b_push + 2);
        repeat (3) tick();
        n_chk++; if (last_fun !== 4'h2) begin n_err++; $display("FAIL aluno_fun: got %h exp 2", last_fun); end
        n_chk++; if (pushed[b_push] !== 8'h00) begin n_err++; $display("FAIL aluno_byte0: got %h exp 00", pushed[b_push]); end
        n_chk++; if (pushed[b_push + 1] !== 8'h02) begin n_err++; $display("FAIL aluno_byte1: got %h exp 02", pushed[b_push + 1]); end
    endtask

    task automatic test_burst();
        int b_push;
        int b_q;
        send_byte(8'hAA); send_byte(8'h0E); send_byte(8'hA1);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'hB2);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'hC3);
        tick();
        b_push = pushed.size();
        b_q = rd_addrs.size();
        send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
        wait_pushes(b_push + 3);
        repeat (4) tick();
        n_chk++; if (rd_addrs.size() != b_q + 3) begin n_err++; $display("FAIL burst_rd_cnt: got %0d exp %0d", rd_addrs.size(), b_q + 3); end
        n_chk++; if (rd_addrs[b_q + 2] !== 4'h0) begin n_err++; $display("FAIL burst_wrap_addr: got %h exp 0", rd_addrs[b_q + 2]); end
        n_chk++; if (pushed[b_push] !== 8'hA1) begin n_err++; $display("FAIL burst_byte0: got %h exp a1", pushed[b_push]); end
        n_chk++; if (pushed[b_push + 1] !== 8'hB2) begin n_err++; $display("FAIL burst_byte1: got %h exp b2", pushed[b_push + 1]); end
        n_chk++; if (pushed[b_push + 2] !== 8'hC3) begin n_err++; $display("FAIL burst_byte2: got %h exp c3", pushed[b_push + 2]); end
        n_chk++; if (pushed.size() != b_push + 3) begin n_err++; $display("FAIL burst_push_cnt: got %0d exp %0d", pushed.size(), b_push + 3); end
    endtask

    task automatic test_burst_zero();
        int b_rd = n_rd;
        int b_ferr = n_ferr;
        send_byte(8'hEE); send_byte(8'h02); send_byte(8'h00);
        repeat (4) tick();
        n_chk++; if (n_ferr - b_ferr != 1) begin n_err++; $display("FAIL bz_ferr: got %0d exp 1", n_ferr - b_ferr); end
        n_chk++; if (n_rd != b_rd) begin n_err++; $display("FAIL bz_no_rd: got %0d exp 0", n_rd - b_rd); end
    endtask

    task automatic test_fifo_full();
        int b_push = pushed.size();
        send_byte(8'hDD);
        bus.FIFO_FULL = 1'b1;
        send_byte(8'h00);
        repeat (8) tick();
        n_chk++; if (pushed.size() != b_push) begin n_err++; $display("FAIL full_no_push: got %0d exp %0d", pushed.size(), b_push); end
        n_chk++; if (bus.FIFO_WrData !== 8'hE3) begin n_err++; $display("FAIL full_data_held: got %h exp e3", bus.FIFO_WrData); end
        n_chk++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %0b exp 1", bus.Busy); end
        bus.FIFO_FULL = 1'b0;
        wait_pushes(b_push + 2);
        repeat (3) tick();
        n_chk++; if (pushed.size() != b_push + 2) begin n_err++; $display("FAIL full_push_cnt: got %0d exp %0d", pushed.size(), b_push + 2); end
        n_chk++; if (pushed[b_push] !== 8'hE3) begin n_err++; $display("FAIL full_byte0: got %h exp e3", pushed[b_push]); end
        n_chk++; if (pushed[b_push + 1] !== 8'h00) begin n_err++; $display("FAIL full_byte1: got %h exp 00", pushed[b_push + 1]); end
    endtask

    task automatic test_timeout();
        int b_wr = n_wr;
        int seen = 0;
        send_byte(8'hAA);
        for (int k = 1; k <= 400 && seen == 0; k++) begin
            tick();
            if (bus.Frame_Err) seen = k;
        end
        n_chk++; if (seen != 255) begin n_err++; $display("FAIL timeout_cycle: got %0d exp 255", seen); end
        tick();
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got %0b exp 0", bus.Busy); end
        n_chk++; if (n_wr != b_wr) begin n_err++; $display("FAIL timeout_no_wr: got %0d exp 0", n_wr - b_wr); end
    endtask

    task automatic test_bad_opcode();
        int b_ferr = n_ferr;
        send_byte(8'h55);
        repeat (2) tick();
        n_chk++; if (n_ferr - b_ferr != 1) begin n_err++; $display("FAIL badop_ferr: got %0d exp 1", n_ferr - b_ferr); end
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL badop_idle: got %0b exp 0", bus.Busy); end
    endtask

    task automatic test_reset_mid_burst();
        int b_push = pushed.size();
        int b_rd;
        send_byte(8'hEE); send_byte(8'h00); send_byte(8'h05);
        wait_pushes(b_push + 1);
        RST = 1'b1;
        tick();
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0b exp 0", bus.Busy); end
        n_chk++; if (bus.RegFile_RdEn !== 1'b0) begin n_err++; $display("FAIL rstmid_rden: got %0b exp 0", bus.RegFile_RdEn); end
        n_chk++; if (bus.FIFO_WrInc !== 1'b0) begin n_err++; $display("FAIL rstmid_wrinc: got %0b exp 0", bus.FIFO_WrInc); end
        n_chk++; if (bus.ClkDiv_EN !== 1'b1) begin n_err++; $display("FAIL rstmid_clkdiv: got %0b exp 1", bus.ClkDiv_EN); end
        tick();
        RST = 1'b0;
        b_push = pushed.size();
        b_rd = n_rd;
        repeat (10) tick();
        n_chk++; if (n_rd != b_rd) begin n_err++; $display("FAIL rstmid_no_rd: got %0d exp 0", n_rd - b_rd); end
        n_chk++; if (pushed.size() != b_push) begin n_err++; $display("FAIL rstmid_no_push: got %0d exp 0", pushed.size() - b_push); end
        n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %0b exp 0", bus.Busy); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        RST           = 1'b1;
        bus.RX_P_Data = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.FIFO_FULL = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_alu_no_ops();
        test_burst();
        test_burst_zero();
        test_fifo_full();
        test_timeout();
        test_bad_opcode();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
